// File: rtl/enoc_switch_allocator_pkg.sv
// enoc_switch_allocator_pkg: router port counts and the clog2 helper shared by the allocator.
package enoc_switch_allocator_pkg;
    localparam int ENOC_N = 5;
    localparam int ENOC_M = 5;
    localparam int ENOC_DEGREE = 4;

    // Never returns 0, so a select index is always at least one bit wide.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/enoc_switch_allocator_if.sv
// enoc_switch_allocator_if: request/enable in, grant/crossbar select out.
interface enoc_switch_allocator_if
    import enoc_switch_allocator_pkg::*;
#(
    parameter int N = ENOC_N,
    parameter int M = ENOC_M,
    parameter int SEL_W = clog2(N)
);
    logic [0:N-1][0:M-1] i_req;
    logic [0:M-1] i_en;
    logic [0:N-1] o_grant;
    logic [0:M-1][SEL_W-1:0] o_sel;
    logic [0:M-1] o_sel_val;
    logic o_err;

    modport master (output i_req, i_en, input o_grant, o_sel, o_sel_val, o_err);
    modport slave (input i_req, i_en, output o_grant, o_sel, o_sel_val, o_err);
endinterface

// File: rtl/enoc_rr_arbiter.sv
// enoc_rr_arbiter: round-robin arbiter for one output port.
// The search starts at ptr, which moves past the winner on every transfer.
module enoc_rr_arbiter #(
    parameter int N = 5,
    parameter int SEL_W = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic [0:N-1] req,
    input  logic en,
    output logic [SEL_W-1:0] winner,
    output logic valid
);
    logic [SEL_W-1:0] ptr;
    logic hit;
    int j;

    always_comb begin
        winner = '0;
        hit = 1'b0;
        j = 0;
        for (int o = 0; o < N; o++) begin
            j = int'(ptr) + o;
            j = (j >= N) ? j - N : j;
            if (!hit && req[j]) begin
                winner = SEL_W'(j);
                hit = 1'b1;
            end
        end
        valid = !reset && en && hit;
    end

    always_ff @(posedge clk) begin
        if (reset) ptr <= '0;
        else if (valid) ptr <= (winner == SEL_W'(N - 1)) ? '0 : winner + 1'b1;
    end
endmodule

// File: rtl/enoc_switch_allocator.sv
// enoc_switch_allocator: per-output round-robin switch allocation between input queues and crossbar.
// A malformed multi-hot request is reduced to its lowest output and flagged in a sticky error.
module enoc_switch_allocator
    import enoc_switch_allocator_pkg::*;
#(
    parameter int N = ENOC_N,
    parameter int M = ENOC_M,
    parameter int SEL_W = clog2(N)
) (
    input  logic clk,
    input  logic reset,
    enoc_switch_allocator_if.slave bus
);
    logic [0:N-1][0:M-1] fix;
    logic [0:M-1][0:N-1] col;
    logic [SEL_W-1:0] win [M];
    logic [0:M-1] val;
    logic malformed;
    logic err;

    always_comb begin
        fix = '0;
        col = '0;
        malformed = 1'b0;
        for (int k = 0; k < N; k++) begin
            malformed = malformed | ($countones(bus.i_req[k]) > 1);
            for (int m = M - 1; m >= 0; m--) begin
                if (bus.i_req[k][m]) begin
                    fix[k] = '0;
                    fix[k][m] = 1'b1;
                end
            end
        end
        for (int m = 0; m < M; m++)
            for (int k = 0; k < N; k++) col[m][k] = fix[k][m];
    end

    for (genvar g = 0; g < M; g++) begin : g_arb
        enoc_rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
            .clk(clk),
            .reset(reset),
            .req(col[g]),
            .en(bus.i_en[g]),
            .winner(win[g]),
            .valid(val[g])
        );
    end

    // Each input requests at most one output after masking, so grants never collide.
    always_comb begin
        bus.o_grant = '0;
        bus.o_sel = '0;
        for (int m = 0; m < M; m++) begin
            bus.o_sel[m] = val[m] ? win[m] : '0;
            if (val[m]) bus.o_grant[win[m]] = 1'b1;
        end
    end

    assign bus.o_sel_val = val;
    assign bus.o_err = err;

    always_ff @(posedge clk) begin
        if (reset) err <= 1'b0;
        else if (malformed) err <= 1'b1;
    end
endmodule

// File: tb/tb_enoc_switch_allocator.sv
// tb_enoc_switch_allocator: directed-vector bench for the switch allocator.
module tb_enoc_switch_allocator;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    enoc_switch_allocator_if #(.N(5), .M(5), .SEL_W(3)) bus ();

    enoc_switch_allocator #(.N(5), .M(5), .SEL_W(3)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    function automatic logic [0:4] onehot(input int k);
        logic [0:4] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        bus.i_en = 5'b11111;
        bus.i_req = '0;
        bus.i_req[1][0] = 1'b1;
        bus.i_req[3][2] = 1'b1;
        settle();
        vectors++;
        if (bus.o_grant !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset_grant got %b want 00000", bus.o_grant);
        end
        vectors++;
        if (bus.o_sel_val !== 5'b00000 || bus.o_sel !== '0) begin
            miscompares++;
            $display("FAIL reset_sel got val %b sel %h want 0/0", bus.o_sel_val, bus.o_sel);
        end
        tick();
        reset = 1'b0;
        bus.i_req = '0;
        settle();
        vectors++;
        if (bus.o_grant !== 5'b00000 || bus.o_sel_val !== 5'b00000 || bus.o_err !== 1'b0) begin
            miscompares++;
            $display("FAIL idle got grant %b val %b err %b want 00000 00000 0", bus.o_grant, bus.o_sel_val, bus.o_err);
        end
        tick();
    endtask

    task automatic test_round_robin;
        int exp_seq[6] = '{1, 2, 4, 1, 2, 4};
        bus.i_en = 5'b11111;
        bus.i_req = '0;
        bus.i_req[1][0] = 1'b1;
        bus.i_req[2][0] = 1'b1;
        bus.i_req[4][0] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            settle();
            vectors++;
            if (bus.o_grant !== onehot(exp_seq[c]) || bus.o_sel[0] !== 3'(exp_seq[c]) || bus.o_sel_val !== 5'b10000) begin
                miscompares++;
                $display("FAIL rr_cycle%0d got grant %b sel0 %0d val %b want grant %b sel0 %0d val 10000",
                         c, bus.o_grant, bus.o_sel[0], bus.o_sel_val, onehot(exp_seq[c]), exp_seq[c]);
            end
            tick();
        end
    endtask

    task automatic test_enable_block;
        bus.i_en = 5'b11111;
        settle();
        vectors++;
        if (bus.o_grant !== onehot(1)) begin
            miscompares++;
            $display("FAIL en_first got %b want %b", bus.o_grant, onehot(1));
        end
        tick();
        bus.i_en = 5'b01111;
        for (int c = 0; c < 3; c++) begin
            settle();
            vectors++;
            if (bus.o_grant !== 5'b00000 || bus.o_sel_val !== 5'b00000 || bus.o_sel[0] !== 3'd0) begin
                miscompares++;
                $display("FAIL en_blocked%0d got grant %b val %b sel0 %0d want 00000 00000 0",
                         c, bus.o_grant, bus.o_sel_val, bus.o_sel[0]);
            end
            tick();
        end
        bus.i_en = 5'b11111;
        settle();
        vectors++;
        if (bus.o_grant !== onehot(2) || bus.o_sel[0] !== 3'd2) begin
            miscompares++;
            $display("FAIL en_resume got grant %b sel0 %0d want %b 2", bus.o_grant, bus.o_sel[0], onehot(2));
        end
        tick();
        settle();
        vectors++;
        if (bus.o_grant !== onehot(4)) begin
            miscompares++;
            $display("FAIL en_next got %b want %b", bus.o_grant, onehot(4));
        end
        tick();
    endtask

    task automatic test_concurrent;
        bus.i_en = 5'b11111;
        bus.i_req = '0;
        bus.i_req[0][2] = 1'b1;
        bus.i_req[3][4] = 1'b1;
        bus.i_req[4][1] = 1'b1;
        settle();
        vectors++;
        if (bus.o_grant !== 5'b10011 || bus.o_sel_val !== 5'b01101) begin
            miscompares++;
            $display("FAIL conc_grant got grant %b val %b want 10011 01101", bus.o_grant, bus.o_sel_val);
        end
        vectors++;
        if (bus.o_sel[2] !== 3'd0 || bus.o_sel[4] !== 3'd3 || bus.o_sel[1] !== 3'd4) begin
            miscompares++;
            $display("FAIL conc_sel got s2 %0d s4 %0d s1 %0d want 0 3 4", bus.o_sel[2], bus.o_sel[4], bus.o_sel[1]);
        end
        tick();
    endtask

    task automatic test_malformed;
        bus.i_req = '0;
        bus.i_req[2] = 5'b01010;
        settle();
        vectors++;
        if (bus.o_err !== 1'b0) begin
            miscompares++;
            $display("FAIL mal_err_before got %b want 0", bus.o_err);
        end
        vectors++;
        if (bus.o_grant !== 5'b00100 || bus.o_sel_val !== 5'b01000 || bus.o_sel[1] !== 3'd2 || bus.o_sel[3] !== 3'd0) begin
            miscompares++;
            $display("FAIL mal_arb got grant %b val %b s1 %0d s3 %0d want 00100 01000 2 0",
                     bus.o_grant, bus.o_sel_val, bus.o_sel[1], bus.o_sel[3]);
        end
        tick();
        bus.i_req = '0;
        for (int c = 0; c < 2; c++) begin
            settle();
            vectors++;
            if (bus.o_err !== 1'b1) begin
                miscompares++;
                $display("FAIL mal_err_sticky%0d got %b want 1", c, bus.o_err);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid;
        bus.i_req = '0;
        bus.i_req[2][0] = 1'b1;
        settle();
        vectors++;
        if (bus.o_grant !== onehot(2)) begin
            miscompares++;
            $display("FAIL rst_adv got %b want %b", bus.o_grant, onehot(2));
        end
        tick();
        bus.i_req = '0;
        bus.i_req[0][0] = 1'b1;
        bus.i_req[3][0] = 1'b1;
        reset = 1'b1;
        settle();
        vectors++;
        if (bus.o_grant !== 5'b00000 || bus.o_sel_val !== 5'b00000 || bus.o_sel[0] !== 3'd0) begin
            miscompares++;
            $display("FAIL rst_during got grant %b val %b sel0 %0d want 00000 00000 0",
                     bus.o_grant, bus.o_sel_val, bus.o_sel[0]);
        end
        tick();
        reset = 1'b0;
        settle();
        vectors++;
        if (bus.o_grant !== onehot(0) || bus.o_sel[0] !== 3'd0 || bus.o_sel_val !== 5'b10000) begin
            miscompares++;
            $display("FAIL rst_resume got grant %b sel0 %0d val %b want %b 0 10000",
                     bus.o_grant, bus.o_sel[0], bus.o_sel_val, onehot(0));
        end
        vectors++;
        if (bus.o_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_err_clear got %b want 0", bus.o_err);
        end
        tick();
        settle();
        vectors++;
        if (bus.o_grant !== onehot(3)) begin
            miscompares++;
            $display("FAIL rst_next got %b want %b", bus.o_grant, onehot(3));
        end
        tick();
    endtask

    initial begin
        bus.i_req = '0;
        bus.i_en = '0;
        #1;
        test_reset();
        test_round_robin();
        test_enable_block();
        test_concurrent();
        test_malformed();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
